instr_encoder_loader: RTL
=========================

// Module: instr_encoder_loader
// PURPOSE
//  Inverse of the control decoder: takes instruction fields as a mnemonic code plus operands and packs them into 32-bit MIPS words.
//  Writes each word sequentially into instruction memory so self-checking benches and the boot loader can build programs in RTL.
//  Covers every opcode the decoder accepts.
//  Sits between a stimulus/loader source (valid/ready) and the instruction-memory write port.
// PARAMETERS
//  DEPTH      256   max words written before full (power of 2, >=2)
//  ADDR_W     8     word-pointer width, = log2(DEPTH)
//  BASE_ADDR  0     byte address of the first written word (word-aligned)
// PORTS
//  clk_i       in   1   clock, rising edge
//  rst_i       in   1   reset, asynchronous, active-high
//  clear_i     in   1   sync: pointer, count, err_o to 0; state to IDLE
//  in_valid_i  in   1   instruction fields valid
//  in_ready_o  out  1   block can accept fields this cycle
//  mnem_i      in   4   0 Rtype,1 addi,2 beq,3 bne,4 lw,5 sw,6 j,7 jal,8 li/lui,9 ori,10 ble,11 blt,12 bnez
//  rs_i        in   5   rs field
//  rt_i        in   5   rt field
//  rd_i        in   5   rd field (R-type only)
//  shamt_i     in   5   shamt field (R-type only)
//  funct_i     in   6   funct field (R-type only)
//  imm_i       in   16  immediate / branch offset
//  target_i    in   26  jump target (j/jal)
//  mem_we_o    out  1   instruction-memory write strobe, one cycle per word
//  mem_addr_o  out  32  byte address = BASE_ADDR + 4*wptr
//  mem_data_o  out  32  encoded word
//  count_o     out  ADDR_W+1  words written since reset/clear
//  full_o      out  1   count_o == DEPTH
//  err_o       out  1   sticky: unsupported mnemonic seen
// BEHAVIOUR
//  Reset: state IDLE, wptr=0, count_o=0, mem_we_o=0, mem_addr_o=BASE_ADDR, mem_data_o=0, full_o=0, err_o=0, in_ready_o=1.
//  FSM IDLE -> ENC -> WR -> IDLE; FULL is terminal until rst_i or clear_i.
//  IDLE: in_ready_o=1. in_valid_i&in_ready_o latches all fields and goes to ENC.
//  ENC: in_ready_o=0. Encodes the latched fields into a word register.
//   - Valid mnemonic -> WR.
//   - Mnemonic 13-15 -> err_o=1, no write, back to IDLE.
//  WR: mem_we_o=1 for exactly this cycle, with the address and data shown on the outputs.
//   - At the end of the cycle: wptr+1, count+1.
//   - Next state FULL if the new count == DEPTH, else IDLE.
//  Latency: handshake in cycle N -> mem_we_o high in cycle N+2. Max throughput is 1 word per 3 cycles.
//  mem_addr_o/mem_data_o hold their last value when mem_we_o=0.
//  Encoding (op = bits 31:26):
//   R  {000000,rs,rt,rd,shamt,funct}
//   I  {op,rs,rt,imm}, ops: addi 001000, beq 000100, bne 000101, lw 100011, sw 101011, ori 001101, ble 000111, blt 000110
//   li/lui  {001111,00000,rt,imm}; rs forced to 0
//   bnez    {000101,rs,00000,imm}; rt forced to 0
//   J  {000010|000011,target}
//  FULL: in_ready_o=0 and mem_we_o=0; full_o=1 is held.
//  clear_i has priority over every FSM transition.
//   - Mid-operation (ENC or WR): the pending word is dropped and no write occurs that cycle.
//   - Handshake in the same cycle as clear_i: the handshake is ignored.
//  rst_i mid-operation: outputs go to reset values immediately (async). No partial write survives.
//  Pointer never wraps; the FULL state prevents overflow.
// TESTING
//  addi rs=1 rt=2 imm=5 -> one write: addr=BASE, data=0x20220005, count_o=1.
//  Rtype rs=1 rt=2 rd=3 shamt=0 funct=0x20 -> data 0x00221820 at cycle N+2. in_ready_o low in N+1..N+2.
//  jal target=0x10 then bnez rs=4 rt=7 imm=0xFFFE:
//   - data 0x0C000010 at addr BASE.
//   - data 0x1480FFFE at addr BASE+4.
//  mnem=14 -> err_o=1 sticky, mem_we_o never asserted, count_o unchanged. clear_i then drops err_o to 0.
//  DEPTH=4, feed 5 valid instructions:
//   - 4 writes at 0,4,8,12; full_o=1; in_ready_o=0; fifth never accepted.
//   - clear_i -> next write at BASE.
//  rst_i asserted during WR -> mem_we_o falls asynchronously, count_o=0. Next accepted word lands at BASE.

Source files
------------

// File: rtl/instr_encoder_loader.sv
// -----------------------------------------------------------------------------
// instr_encoder_loader
//   Packs mnemonic + operand fields into 32-bit MIPS instruction words and
//   writes them one after another into instruction memory, starting at
//   BASE_ADDR. It is the inverse of the control decoder and lets benches and
//   the boot loader assemble programs in hardware.
//
//   Ports
//     clk_i, rst_i        clock (rising edge), async active-high reset
//     clear_i             sync clear: pointer, count, error flag, FSM to IDLE
//     in_valid_i/_ready_o field handshake from the loader source
//     mnem_i              0 R,1 addi,2 beq,3 bne,4 lw,5 sw,6 j,7 jal,8 lui,
//                         9 ori,10 ble,11 blt,12 bnez (13-15 unsupported)
//     rs_i..target_i      instruction fields
//     mem_we_o            one-cycle write strobe per encoded word
//     mem_addr_o          byte address of the word being written
//     mem_data_o          encoded word
//     count_o             words written since reset/clear
//     full_o              DEPTH words written; no more accepted
//     err_o               sticky: an unsupported mnemonic was seen
// -----------------------------------------------------------------------------
module instr_encoder_loader #(
  parameter int          DEPTH     = 256,
  parameter int          ADDR_W    = 8,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              clear_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [3:0]        mnem_i,
  input  logic [4:0]        rs_i,
  input  logic [4:0]        rt_i,
  input  logic [4:0]        rd_i,
  input  logic [4:0]        shamt_i,
  input  logic [5:0]        funct_i,
  input  logic [15:0]       imm_i,
  input  logic [25:0]       target_i,
  output logic              mem_we_o,
  output logic [31:0]       mem_addr_o,
  output logic [31:0]       mem_data_o,
  output logic [ADDR_W:0]   count_o,
  output logic              full_o,
  output logic              err_o
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ENC  = 2'd1;
  localparam logic [1:0] S_WR   = 2'd2;
  localparam logic [1:0] S_FULL = 2'd3;

  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] ONE_C   = (ADDR_W+1)'(1);

  logic [1:0]      state_q, state_d;
  logic [ADDR_W:0] count_q, count_d;
  logic            err_q, err_d;
  logic [31:0]     addr_q, addr_d;
  logic [31:0]     data_q, data_d;

  // Latched instruction fields
  logic [3:0]  mnem_q;
  logic [4:0]  rs_q, rt_q, rd_q, shamt_q;
  logic [5:0]  funct_q;
  logic [15:0] imm_q;
  logic [25:0] target_q;

  logic            accept;
  logic            enc_ok;
  logic [31:0]     enc_word;
  logic [ADDR_W:0] count_inc;

  // A handshake coinciding with clear_i is ignored.
  assign accept    = in_valid_i && (state_q == S_IDLE) && !clear_i;
  assign count_inc = count_q + ONE_C;

  // NOTE: field registers are pure datapath, only read after a handshake has
  // loaded them, so they carry no reset and cost no reset routing.
  always_ff @(posedge clk_i) begin
    if (accept) begin
      mnem_q   <= mnem_i;
      rs_q     <= rs_i;
      rt_q     <= rt_i;
      rd_q     <= rd_i;
      shamt_q  <= shamt_i;
      funct_q  <= funct_i;
      imm_q    <= imm_i;
      target_q <= target_i;
    end
  end

  // Word encoder over the latched fields.
  always_comb begin
    // NOTE: every combinational output gets a default before the case so no
    // path leaves it unassigned (which would infer a latch).
    enc_ok   = 1'b1;
    enc_word = 32'h0;
    case (mnem_q)
      4'd0:  enc_word = {6'b000000, rs_q, rt_q, rd_q, shamt_q, funct_q};
      4'd1:  enc_word = {6'b001000, rs_q, rt_q, imm_q};
      4'd2:  enc_word = {6'b000100, rs_q, rt_q, imm_q};
      4'd3:  enc_word = {6'b000101, rs_q, rt_q, imm_q};
      4'd4:  enc_word = {6'b100011, rs_q, rt_q, imm_q};
      4'd5:  enc_word = {6'b101011, rs_q, rt_q, imm_q};
      4'd6:  enc_word = {6'b000010, target_q};
      4'd7:  enc_word = {6'b000011, target_q};
      4'd8:  enc_word = {6'b001111, 5'b00000, rt_q, imm_q};  // lui: rs forced 0
      4'd9:  enc_word = {6'b001101, rs_q, rt_q, imm_q};
      4'd10: enc_word = {6'b000111, rs_q, rt_q, imm_q};
      4'd11: enc_word = {6'b000110, rs_q, rt_q, imm_q};
      4'd12: enc_word = {6'b000101, rs_q, 5'b00000, imm_q};  // bnez: rt forced 0
      default: enc_ok = 1'b0;
    endcase
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    err_d   = err_q;
    addr_d  = addr_q;
    data_d  = data_q;
    case (state_q)
      S_IDLE: if (accept) state_d = S_ENC;
      S_ENC: begin
        if (enc_ok) begin
          // Address/data are captured here so they hold after the write.
          data_d  = enc_word;
          addr_d  = BASE_ADDR + 32'({count_q[ADDR_W-1:0], 2'b00});
          state_d = S_WR;
        end else begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end
      end
      S_WR: begin
        count_d = count_inc;
        state_d = (count_inc == DEPTH_C) ? S_FULL : S_IDLE;
      end
      default: state_d = S_FULL;  // terminal until reset or clear
    endcase
    // Clear overrides everything; a pending word is dropped and the
    // visible address/data keep their last written values.
    if (clear_i) begin
      state_d = S_IDLE;
      count_d = '0;
      err_d   = 1'b0;
      addr_d  = addr_q;
      data_d  = data_q;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      count_q <= '0;
      err_q   <= 1'b0;
      addr_q  <= BASE_ADDR;
      data_q  <= 32'h0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      err_q   <= err_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
    end
  end

  // Write strobe is suppressed combinationally when clear_i lands in WR.
  assign mem_we_o   = (state_q == S_WR) && !clear_i;
  assign mem_addr_o = addr_q;
  assign mem_data_o = data_q;
  assign in_ready_o = (state_q == S_IDLE);
  assign full_o     = (state_q == S_FULL);
  assign count_o    = count_q;
  assign err_o      = err_q;

endmodule
